// File: rtl/display_out_port.sv
// display_out_port: memory-mapped buffered output port.
// The CPU pushes 16-bit words into a small FIFO. A drain FSM moves each word onto
// disp_out and holds it there for HOLD_CYCLES clocks before taking the next one.
// Software can poll the status word or use the level interrupt, which is raised
// when everything that was queued has been shown.
//
// state | meaning
// IDLE  | nothing on hold; the next queued word is taken at the next edge
// HOLD  | disp_out is being held; timer counts down to 0
module display_out_port #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic        rd,
  input  logic        a0,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        interrupt,
  output logic [15:0] disp_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [3:0]    DEPTH_C      = 4'(DEPTH);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(HOLD_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [15:0]     mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [3:0]      count;
  logic            ie;
  logic            ovf;

  logic            push_req;
  logic            ctrl_wr;
  logic            flush;
  logic            pop;
  logic            push_ok;
  logic            empty;
  logic            ready;
  logic            busy;
  logic [15:0]     head;

  // Reads have no side effects, so the strobe is intentionally not used.
  logic            unused_rd;
  assign unused_rd = rd;

  assign push_req = wr & ~a0;
  assign ctrl_wr  = wr & a0;
  assign flush    = ctrl_wr & wdata[2];
  assign empty    = (count == 4'd0);
  assign ready    = (count < DEPTH_C);
  assign busy     = (state == HOLD);
  assign head     = mem[rptr];

  // The FSM takes a word whenever it is idle or its hold has just expired; a flush overrides it.
  assign pop      = !flush && !empty && ((state == IDLE) || (timer == '0));
  // A full FIFO still accepts a word if a slot frees at the same edge.
  assign push_ok  = push_req && ((count != DEPTH_C) || pop);

  assign interrupt = ie & empty & (state == IDLE);
  assign rdata     = a0 ? {4'b0, count, 3'b0, busy, ie, ovf, empty, ready} : disp_out;

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= wdata;
  end

  // Write pointer, occupancy count and the control/status bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      count <= 4'd0;
      ie    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(1);

      if (flush)                       count <= 4'd0;
      else if (push_ok && !pop)        count <= count + 4'd1;
      else if (!push_ok && pop)        count <= count - 4'd1;

      if (push_req && !push_ok)        ovf <= 1'b1;
      else if (ctrl_wr && wdata[1])    ovf <= 1'b0;

      if (ctrl_wr) ie <= wdata[0];
    end
  end

  // Drain FSM: shows each queued word for HOLD_CYCLES clocks, back to back when data is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      rptr     <= '0;
      disp_out <= 16'h0000;
    end else if (flush) begin
      // Discard queued words by catching the read pointer up; disp_out is left alone.
      state <= IDLE;
      timer <= '0;
      rptr  <= wptr;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            disp_out <= head;
            rptr     <= rptr + PW'(1);
            timer    <= TIMER_RELOAD;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (!empty) begin
            disp_out <= head;
            rptr     <= rptr + PW'(1);
            timer    <= TIMER_RELOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_out_port.sv
// Directed bench for display_out_port (DEPTH=4, HOLD_CYCLES=4).
// Inputs change and outputs are sampled shortly after each rising edge.
module tb_display_out_port;

  logic        clk;
  logic        rst_n;
  logic        wr;
  logic        rd;
  logic        a0;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        interrupt;
  logic [15:0] disp_out;

  int n_checks = 0;
  int n_fail   = 0;

  display_out_port #(.DEPTH(4), .HOLD_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr        (wr),
    .rd        (rd),
    .a0        (a0),
    .wdata     (wdata),
    .rdata     (rdata),
    .interrupt (interrupt),
    .disp_out  (disp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_word(input logic sel, input logic [15:0] d);
    wr    = 1'b1;
    a0    = sel;
    wdata = d;
    @(posedge clk);
    #1;
    wr    = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic [15:0] exp);
    a0 = 1'b1;
    rd = 1'b1;
    #1;
    chk(tag, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic chk_data_reg(input string tag, input logic [15:0] exp);
    a0 = 1'b0;
    rd = 1'b1;
    #1;
    chk(tag, rdata, exp);
    rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      a0 = 1'b1;
      #1;
      if (rdata[4] == 1'b0 && rdata[1] == 1'b1) done = 1'b1;
      else step(1);
    end
    chk(tag, {15'b0, done}, 16'h0001);
  endtask

  logic [15:0] slow_words [6];

  initial begin
    rst_n = 1'b0;
    wr    = 1'b0;
    rd    = 1'b0;
    a0    = 1'b0;
    wdata = 16'h0000;
    slow_words[0] = 16'h1111; slow_words[1] = 16'h2222; slow_words[2] = 16'h3333;
    slow_words[3] = 16'h4444; slow_words[4] = 16'h5555; slow_words[5] = 16'h6666;

    // ---- reset values
    step(2);
    chk("rst_disp", disp_out, 16'h0000);
    chk("rst_irq", {15'b0, interrupt}, 16'h0000);
    chk_status("rst_status", 16'h0003);
    rst_n = 1'b1;
    step(1);

    // ---- reset mid-HOLD with 3 words queued
    wr_word(1'b0, 16'hA001);
    wr_word(1'b0, 16'hA002);
    wr_word(1'b0, 16'hA003);
    wr_word(1'b0, 16'hA004);
    chk("pre_rst_disp", disp_out, 16'hA001);
    chk_status("pre_rst_status", 16'h0311);
    rst_n = 1'b0;
    #1;
    chk("async_rst_disp", disp_out, 16'h0000);
    chk("async_rst_irq", {15'b0, interrupt}, 16'h0000);
    chk_status("async_rst_status", 16'h0003);
    step(2);
    rst_n = 1'b1;
    step(1);

    // ---- single word
    wr_word(1'b0, 16'h1234);
    chk("single_disp_n", disp_out, 16'h0000);
    chk_status("single_status_n", 16'h0101);
    step(1);
    chk("single_disp_n1", disp_out, 16'h1234);
    chk_data_reg("single_rdata", 16'h1234);
    chk_status("single_busy_n1", 16'h0013);
    step(3);
    chk_status("single_busy_n4", 16'h0013);
    step(1);
    chk_status("single_idle_n5", 16'h0003);
    chk("single_hold_last", disp_out, 16'h1234);

    // ---- burst A,B,C,D back-to-back
    wr_word(1'b0, 16'h00AA);
    wr_word(1'b0, 16'h00BB);
    wr_word(1'b0, 16'h00CC);
    wr_word(1'b0, 16'h00DD);
    chk("burst_a", disp_out, 16'h00AA);
    chk_status("burst_cnt3", 16'h0311);
    step(1);
    chk("burst_a_held", disp_out, 16'h00AA);
    step(1);
    chk("burst_b", disp_out, 16'h00BB);
    chk_status("burst_cnt2", 16'h0211);
    step(3);
    chk("burst_b_held", disp_out, 16'h00BB);
    step(1);
    chk("burst_c", disp_out, 16'h00CC);
    chk_status("burst_cnt1", 16'h0111);
    step(4);
    chk("burst_d", disp_out, 16'h00DD);
    chk_status("burst_cnt0", 16'h0013);
    step(4);
    chk_status("burst_idle", 16'h0003);

    // ---- overflow while stalled in HOLD
    wr_word(1'b0, 16'hB000);
    wr_word(1'b0, 16'hB001);
    wr_word(1'b0, 16'hB002);
    wr_word(1'b0, 16'hB003);
    wr_word(1'b0, 16'hB004);
    chk_status("ovf_full_pre", 16'h0410);
    wr_word(1'b0, 16'hB005);
    chk_status("ovf_full_pop_push", 16'h0410);
    chk("ovf_disp_b1", disp_out, 16'hB001);
    wr_word(1'b0, 16'hB006);
    chk_status("ovf_set", 16'h0414);
    wr_word(1'b1, 16'h0002);
    chk_status("ovf_clear", 16'h0410);
    wait_idle("ovf_drain_timeout");
    chk("ovf_last_kept", disp_out, 16'hB005);

    // ---- interrupt
    chk("irq_off_ie0", {15'b0, interrupt}, 16'h0000);
    wr_word(1'b1, 16'h0001);
    chk("irq_on", {15'b0, interrupt}, 16'h0001);
    chk_status("irq_status", 16'h000B);
    wr_word(1'b0, 16'hC0DE);
    chk("irq_push_off", {15'b0, interrupt}, 16'h0000);
    step(1);
    chk("irq_hold_off", {15'b0, interrupt}, 16'h0000);
    wait_idle("irq_drain_timeout");
    chk("irq_back_on", {15'b0, interrupt}, 16'h0001);
    wr_word(1'b1, 16'h0000);
    chk("irq_ie_off", {15'b0, interrupt}, 16'h0000);

    // ---- flush mid-HOLD
    wr_word(1'b0, 16'hD001);
    wr_word(1'b0, 16'hD002);
    wr_word(1'b0, 16'hD003);
    chk_status("flush_pre", 16'h0211);
    wr_word(1'b1, 16'h0004);
    chk_status("flush_status", 16'h0003);
    chk("flush_disp_kept", disp_out, 16'hD001);
    step(6);
    chk("flush_disp_stays", disp_out, 16'hD001);
    chk_status("flush_stays_idle", 16'h0003);

    // ---- slow pushes wrap the pointers
    for (int k = 0; k < 6; k++) begin
      wr_word(1'b0, slow_words[k]);
      step(1);
      chk($sformatf("wrap_word%0d", k), disp_out, slow_words[k]);
      wait_idle($sformatf("wrap_timeout%0d", k));
    end
    chk_status("wrap_final", 16'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
